uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among four byte requesters. Each accepted byte is optionally preceded by a source-ID header byte. The block sits between on-chip byte producers (switch/key capture, receive-echo path, status reporters) and the UART transmit start/busy handshake. It sequences one frame at a time and flags a transmitter that never responds.

---
 rtl/uart_tx_scheduler.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Round-robin scheduler that lets four byte requesters share one UART
// transmitter. In the idle state it grants one requester, acknowledges it and
// starts a transmit. When HEADER_EN is set, a source-ID header byte
// (8'hA0 | id) is sent before the data byte. After each tx_start the block
// waits for tx_busy. If tx_busy does not rise within TIMEOUT cycles, it sets a
// sticky error flag and abandons the frame.
//
// Parameters
//   N_REQ      number of requesters (fixed at 4, id width 2)
//   HEADER_EN  1: prefix every data byte with header 8'hA0 | id
//   TIMEOUT    cycles to wait for tx_busy after tx_start (2..255)
//
// Ports
//   CLOCK_125_p  in   block clock
//   reset        in   synchronous active-high reset
//   req          in   level request per requester, held until ack
//   req_data     in   byte of requester i on [8i+7:8i]
//   ack          out  one-cycle pulse, byte of requester i captured
//   tx_start     out  one-cycle start pulse to the UART transmitter
//   tx_data      out  byte being transmitted, stable until tx_done
//   tx_busy      in   UART transmitter busy
//   tx_done      in   one-cycle pulse at end of stop bit
//   cur_id       out  id of the current or most recent grantee
//   active       out  high whenever the scheduler is not idle
//   err_timeout  out  sticky busy-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int N_REQ     = 4,
  parameter bit HEADER_EN = 1'b0,
  parameter int TIMEOUT   = 16
) (
  input  logic                 CLOCK_125_p,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [1:0]           cur_id,
  output logic                 active,
  output logic                 err_timeout
);

  localparam int             ID_W      = 2;
  localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_HDR_WAIT_BUSY = 3'd1,
    ST_HDR_WAIT_DONE = 3'd2,
    ST_DAT_WAIT_BUSY = 3'd3,
    ST_DAT_WAIT_DONE = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     ptr_nxt_s;
  logic [7:0]          data_r;
  logic [7:0]          data_nxt_s;
  logic [7:0]          cnt_r;
  logic [7:0]          cnt_nxt_s;

  logic [N_REQ-1:0]    ack_r;
  logic [N_REQ-1:0]    ack_nxt_s;
  logic                tx_start_r;
  logic                tx_start_nxt_s;
  logic [7:0]          tx_data_r;
  logic [7:0]          tx_data_nxt_s;
  logic [ID_W-1:0]     cur_id_r;
  logic [ID_W-1:0]     cur_id_nxt_s;
  logic                active_r;
  logic                active_nxt_s;
  logic                err_timeout_r;
  logic                err_timeout_nxt_s;

  logic                grant_found_s;
  logic [ID_W-1:0]     grant_id_s;
  logic [7:0]          grant_byte_s;
  logic                timeout_hit_s;

  // Header byte announcing which requester the following data byte came from.
  function automatic logic [7:0] header_byte(input logic [ID_W-1:0] id);
    return 8'hA0 | {6'b000000, id};
  endfunction

  assign ack         = ack_r;
  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign cur_id      = cur_id_r;
  assign active      = active_r;
  assign err_timeout = err_timeout_r;

  // The wait counter starts at 0 in the cycle after tx_start. Reaching
  // TIMEOUT therefore fires on the (TIMEOUT+1)-th edge after the start pulse.
  assign timeout_hit_s = (cnt_r == TIMEOUT_C);

  // Round-robin search: the first asserted request at or after ptr wins,
  // wrapping naturally through the 2-bit index.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx           = 2'd0;
    grant_found_s = 1'b0;
    grant_id_s    = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_r + i[ID_W-1:0];
      if (req[idx] && !grant_found_s) begin
        grant_found_s = 1'b1;
        grant_id_s    = idx;
      end else begin
        grant_id_s    = grant_id_s;
      end
    end
  end

  // Byte presented by the winning requester.
  assign grant_byte_s = req_data[{grant_id_s, 3'b000} +: 8];

  // State register.
  always_ff @(posedge CLOCK_125_p) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. tx_done wins over tx_busy so that a missed busy edge
  // still completes the frame, and busy wins over a coincident timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          if (HEADER_EN) begin
            state_nxt_s = ST_HDR_WAIT_BUSY;
          end else begin
            state_nxt_s = ST_DAT_WAIT_BUSY;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR_WAIT_BUSY: begin
        if (tx_done) begin
          state_nxt_s = ST_DAT_WAIT_BUSY;
        end else if (tx_busy) begin
          state_nxt_s = ST_HDR_WAIT_DONE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HDR_WAIT_BUSY;
        end
      end
      ST_HDR_WAIT_DONE: begin
        if (tx_done) begin
          state_nxt_s = ST_DAT_WAIT_BUSY;
        end else begin
          state_nxt_s = ST_HDR_WAIT_DONE;
        end
      end
      ST_DAT_WAIT_BUSY: begin
        if (tx_done) begin
          state_nxt_s = ST_IDLE;
        end else if (tx_busy) begin
          state_nxt_s = ST_DAT_WAIT_DONE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DAT_WAIT_BUSY;
        end
      end
      ST_DAT_WAIT_DONE: begin
        if (tx_done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DAT_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values. Every output is registered, so these
  // values appear one cycle after the decision.
  always_comb begin
    ack_nxt_s         = {N_REQ{1'b0}};
    tx_start_nxt_s    = 1'b0;
    tx_data_nxt_s     = tx_data_r;
    cur_id_nxt_s      = cur_id_r;
    ptr_nxt_s         = ptr_r;
    data_nxt_s        = data_r;
    cnt_nxt_s         = 8'd0;
    err_timeout_nxt_s = err_timeout_r;
    active_nxt_s      = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          ack_nxt_s[grant_id_s] = 1'b1;
          tx_start_nxt_s        = 1'b1;
          cur_id_nxt_s          = grant_id_s;
          ptr_nxt_s             = grant_id_s + 2'd1;
          data_nxt_s            = grant_byte_s;
          if (HEADER_EN) begin
            tx_data_nxt_s = header_byte(grant_id_s);
          end else begin
            tx_data_nxt_s = grant_byte_s;
          end
        end else begin
          tx_start_nxt_s = 1'b0;
        end
      end
      ST_HDR_WAIT_BUSY: begin
        if (tx_done) begin
          // Header finished without a visible busy phase; go on to data.
          tx_start_nxt_s = 1'b1;
          tx_data_nxt_s  = data_r;
        end else if (tx_busy) begin
          cnt_nxt_s = 8'd0;
        end else if (timeout_hit_s) begin
          // Header never started: the captured data byte is dropped as well.
          err_timeout_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_HDR_WAIT_DONE: begin
        if (tx_done) begin
          tx_start_nxt_s = 1'b1;
          tx_data_nxt_s  = data_r;
        end else begin
          tx_start_nxt_s = 1'b0;
        end
      end
      ST_DAT_WAIT_BUSY: begin
        if (tx_done) begin
          cnt_nxt_s = 8'd0;
        end else if (tx_busy) begin
          cnt_nxt_s = 8'd0;
        end else if (timeout_hit_s) begin
          err_timeout_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_DAT_WAIT_DONE: begin
        cnt_nxt_s = 8'd0;
      end
      default: begin
        cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge CLOCK_125_p) begin
    if (reset) begin
      ack_r         <= {N_REQ{1'b0}};
      tx_start_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      cur_id_r      <= 2'd0;
      active_r      <= 1'b0;
      err_timeout_r <= 1'b0;
      ptr_r         <= 2'd0;
      data_r        <= 8'h00;
      cnt_r         <= 8'd0;
    end else begin
      ack_r         <= ack_nxt_s;
      tx_start_r    <= tx_start_nxt_s;
      tx_data_r     <= tx_data_nxt_s;
      cur_id_r      <= cur_id_nxt_s;
      active_r      <= active_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
      ptr_r         <= ptr_nxt_s;
      data_r        <= data_nxt_s;
      cnt_r         <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler. dut0 runs without headers and dut1
// runs with headers, both with TIMEOUT=16. A cycle-by-cycle vector table
// covers a single request, a simultaneous busy/done and pointer rotation.
// Hand-written sequences cover round-robin fairness, header framing,
// timeout and a reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  req0, req1;
  logic [31:0] data0, data1;
  logic        busy0, busy1, done0, done1;
  logic [3:0]  ack0, ack1;
  logic        start0, start1;
  logic [7:0]  txd0, txd1;
  logic [1:0]  id0, id1;
  logic        act0, act1;
  logic        err0, err1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(4), .HEADER_EN(1'b0), .TIMEOUT(16)) dut0 (
    .CLOCK_125_p(clk), .reset(reset), .req(req0), .req_data(data0),
    .ack(ack0), .tx_start(start0), .tx_data(txd0), .tx_busy(busy0),
    .tx_done(done0), .cur_id(id0), .active(act0), .err_timeout(err0)
  );

  uart_tx_scheduler #(.N_REQ(4), .HEADER_EN(1'b1), .TIMEOUT(16)) dut1 (
    .CLOCK_125_p(clk), .reset(reset), .req(req1), .req_data(data1),
    .ack(ack1), .tx_start(start1), .tx_data(txd1), .tx_busy(busy1),
    .tx_done(done1), .cur_id(id1), .active(act1), .err_timeout(err1)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [3:0]  e_ack;
    logic        e_start;
    logic [7:0]  e_data;
    logic [1:0]  e_id;
    logic        e_active;
    logic        e_err;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_outs0(input string nm, input logic [3:0] e_ack, input logic e_start,
                             input logic [7:0] e_data, input logic [1:0] e_id,
                             input logic e_active, input logic e_err);
    check({nm, ".ack"},    32'(ack0),   32'(e_ack));
    check({nm, ".start"},  32'(start0), 32'(e_start));
    check({nm, ".data"},   32'(txd0),   32'(e_data));
    check({nm, ".id"},     32'(id0),    32'(e_id));
    check({nm, ".active"}, 32'(act0),   32'(e_active));
    check({nm, ".err"},    32'(err0),   32'(e_err));
  endtask

  initial begin
    reset = 1'b1;
    req0 = 4'b0000; data0 = 32'h0; busy0 = 1'b0; done0 = 1'b0;
    req1 = 4'b0000; data1 = 32'h0; busy1 = 1'b0; done1 = 1'b0;

    // name, rst, req, data, busy, done | ack, start, data, id, active, err
    vecs[0]  = '{"reset",      1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{"grant2",     1'b0, 4'b0100, 32'h005A0000, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h5A, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{"wait1",      1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{"wait2",      1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
    vecs[4]  = '{"busy_rise",  1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{"busy_hold1", 1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{"busy_hold2", 1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{"done",       1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{"wrap_grant0",1'b0, 4'b0001, 32'h000000C3, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hC3, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{"busy_done",  1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hC3, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{"idle_noerr", 1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hC3, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{"grant3",     1'b0, 4'b1000, 32'h77000000, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h77, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{"busy3",      1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h77, 2'd3, 1'b1, 1'b0};
    vecs[13] = '{"done3",      1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd3, 1'b0, 1'b0};

    for (int v = 0; v < 14; v++) begin
      reset = vecs[v].rst;
      req0  = vecs[v].req;
      data0 = vecs[v].rdata;
      busy0 = vecs[v].busy;
      done0 = vecs[v].done;
      tick();
      check_outs0(vecs[v].name, vecs[v].e_ack, vecs[v].e_start, vecs[v].e_data,
                  vecs[v].e_id, vecs[v].e_active, vecs[v].e_err);
    end
    busy0 = 1'b0; done0 = 1'b0; req0 = 4'b0000;

    // Round-robin fairness: all four requesters held high for eight frames.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0  = 4'b1111;
    data0 = 32'h44332211;
    tick();
    for (int f = 0; f < 8; f++) begin
      logic [1:0] e;
      logic [7:0] eb;
      e  = 2'(f % 4);
      eb = 8'(17 * ((f % 4) + 1));
      check("rr.ack",   32'(ack0),   32'(4'b0001 << e));
      check("rr.start", 32'(start0), 32'd1);
      check("rr.id",    32'(id0),    32'(e));
      check("rr.data",  32'(txd0),   32'(eb));
      busy0 = 1'b1;
      tick();
      check("rr.ack_once", 32'(ack0), 32'd0);
      check("rr.active",   32'(act0), 32'd1);
      busy0 = 1'b0; done0 = 1'b1;
      tick();
      check("rr.end_active", 32'(act0), 32'd0);
      check("rr.gap_ack",    32'(ack0), 32'd0);
      done0 = 1'b0;
      tick();
    end
    req0 = 4'b0000;

    // Header framing on dut1: requester 3 sends 8'h41.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req1  = 4'b1000;
    data1 = 32'h41000000;
    tick();
    check("hdr.ack",   32'(ack1),   32'h8);
    check("hdr.start", 32'(start1), 32'd1);
    check("hdr.byte",  32'(txd1),   32'hA3);
    check("hdr.id",    32'(id1),    32'd3);
    req1 = 4'b0000; data1 = 32'h0;
    busy1 = 1'b1;
    tick();
    check("hdr.hold", 32'(txd1), 32'hA3);
    busy1 = 1'b0; done1 = 1'b1;
    tick();
    check("hdr.dat_start", 32'(start1), 32'd1);
    check("hdr.dat_byte",  32'(txd1),   32'h41);
    check("hdr.no_ack",    32'(ack1),   32'd0);
    done1 = 1'b0; busy1 = 1'b1;
    tick();
    check("hdr.dat_single", 32'(start1), 32'd0);
    check("hdr.dat_active", 32'(act1),   32'd1);
    busy1 = 1'b0; done1 = 1'b1;
    tick();
    check("hdr.end_active", 32'(act1), 32'd0);
    check("hdr.end_data",   32'(txd1), 32'h41);
    done1 = 1'b0;

    // Timeout: tx_busy held low after the start pulse.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0  = 4'b0010;
    data0 = 32'h0000EE00;
    tick();
    check("to.start", 32'(start0), 32'd1);
    req0 = 4'b0000;
    for (int c = 1; c <= 16; c++) begin
      tick();
    end
    check("to.err_before",    32'(err0), 32'd0);
    check("to.active_before", 32'(act0), 32'd1);
    tick();
    check("to.err_at17",  32'(err0), 32'd1);
    check("to.idle_at17", 32'(act0), 32'd0);
    req0  = 4'b0001;
    data0 = 32'h00000099;
    tick();
    check("to.next_ack",  32'(ack0), 32'h1);
    check("to.next_data", 32'(txd0), 32'h99);
    req0 = 4'b0000;
    busy0 = 1'b1;
    tick();
    busy0 = 1'b0; done0 = 1'b1;
    tick();
    done0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
    end
    check("to.err_sticky", 32'(err0), 32'd1);
    reset = 1'b1;
    tick();
    check("to.err_cleared", 32'(err0), 32'd0);
    reset = 1'b0;

    // Reset during DAT_WAIT_DONE with ptr pointing at requester 3.
    req0  = 4'b0100;
    data0 = 32'h00AB0000;
    tick();
    check("rst.grant2", 32'(id0), 32'd2);
    req0 = 4'b0000;
    busy0 = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_outs0("rst.mid", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    busy0 = 1'b0;
    req0  = 4'b1111;
    data0 = 32'h44332211;
    tick();
    check("rst.ptr_ack", 32'(ack0), 32'h1);
    check("rst.ptr_id",  32'(id0),  32'd0);
    req0 = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
